// File: rtl/bus_cycle_ctrl.sv
// Minimum-mode 8088 bus cycle sequencer: runs T1-T2-T3-(TW)-T4 for one-byte
// memory/IO transfers and hands the bus to an external master over HOLD/HLDA.
module bus_cycle_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [19:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  input  logic        READY,
  input  logic        HOLD,
  output logic        HLDA,
  output logic        ALE,
  output logic        IOM,
  output logic        RD,
  output logic        WR,
  output logic        DTR,
  output logic        DEN,
  output logic        SSO,
  output logic [7:0]  ad_out,
  output logic        ad_oe,
  input  logic [7:0]  ad_in,
  output logic [11:0] a_out,
  output logic        a_oe
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_TW, S_T4, S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic              wr_q, wr_d, io_q, io_d;
  logic [19:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ale_q, ale_d, rd_q, rd_d, wrs_q, wrs_d, den_q, den_d;
  logic              dtr_q, dtr_d, iom_q, iom_d, sso_q, sso_d, hlda_q, hlda_d;
  logic              adoe_q, adoe_d, aoe_q, aoe_d, rspv_q, rspv_d;
  logic [7:0]        adout_q, adout_d;
  logic [11:0]       aout_q, aout_d;

  assign req_ready = (state_q == S_IDLE) && !HOLD && !RESET;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    io_d    = io_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wait_d  = wait_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (HOLD) begin
          state_d = S_HOLD;
        end else if (req_valid) begin
          wr_d    = req_write;
          io_d    = req_io;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = S_T1;
        end
      end
      S_T1: begin
        wait_d  = '0;
        state_d = S_T2;
      end
      S_T2: state_d = S_T3;
      S_T3, S_TW: begin
        if (READY) begin
          state_d = S_T4;
          if (!wr_q) rdata_d = ad_in;
        end else if ((state_q == S_TW) && (wait_q >= WAIT_W'(MAX_WAIT))) begin
          state_d = S_T4;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d = S_TW;
          wait_d  = wait_q + WAIT_W'(1);
        end
      end
      S_T4:    state_d = S_IDLE;
      S_HOLD:  if (!HOLD) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pin values are decoded from the upcoming state so every output is a flop.
    ale_d   = 1'b0;
    rd_d    = 1'b1;
    wrs_d   = 1'b1;
    den_d   = 1'b1;
    dtr_d   = 1'b1;
    iom_d   = 1'b0;
    sso_d   = 1'b0;
    hlda_d  = 1'b0;
    adoe_d  = 1'b0;
    aoe_d   = 1'b0;
    rspv_d  = 1'b0;
    adout_d = '0;
    aout_d  = '0;
    unique case (state_d)
      S_T1: begin
        ale_d   = 1'b1;
        aoe_d   = 1'b1;
        adoe_d  = 1'b1;
        aout_d  = addr_d[19:8];
        adout_d = addr_d[7:0];
        iom_d   = io_d;
        dtr_d   = wr_d;
        sso_d   = wr_d;
      end
      S_T2, S_T3, S_TW: begin
        aoe_d  = 1'b1;
        aout_d = addr_d[19:8];
        iom_d  = io_d;
        dtr_d  = wr_d;
        sso_d  = wr_d;
        den_d  = 1'b0;
        if (wr_d) begin
          adoe_d  = 1'b1;
          adout_d = wdata_d;
          wrs_d   = 1'b0;
        end else begin
          rd_d = 1'b0;
        end
      end
      S_T4: begin
        aout_d = addr_d[19:8];
        iom_d  = io_d;
        dtr_d  = wr_d;
        sso_d  = wr_d;
        rspv_d = 1'b1;
      end
      S_HOLD:  hlda_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wait_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ale_q   <= 1'b0;
      rd_q    <= 1'b1;
      wrs_q   <= 1'b1;
      den_q   <= 1'b1;
      dtr_q   <= 1'b1;
      iom_q   <= 1'b0;
      sso_q   <= 1'b0;
      hlda_q  <= 1'b0;
      adoe_q  <= 1'b0;
      aoe_q   <= 1'b0;
      rspv_q  <= 1'b0;
      adout_q <= '0;
      aout_q  <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      io_q    <= io_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wait_q  <= wait_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ale_q   <= ale_d;
      rd_q    <= rd_d;
      wrs_q   <= wrs_d;
      den_q   <= den_d;
      dtr_q   <= dtr_d;
      iom_q   <= iom_d;
      sso_q   <= sso_d;
      hlda_q  <= hlda_d;
      adoe_q  <= adoe_d;
      aoe_q   <= aoe_d;
      rspv_q  <= rspv_d;
      adout_q <= adout_d;
      aout_q  <= aout_d;
    end
  end

  assign rsp_valid = rspv_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign HLDA      = hlda_q;
  assign ALE       = ale_q;
  assign IOM       = iom_q;
  assign RD        = rd_q;
  assign WR        = wrs_q;
  assign DTR       = dtr_q;
  assign DEN       = den_q;
  assign SSO       = sso_q;
  assign ad_out    = adout_q;
  assign ad_oe     = adoe_q;
  assign a_out     = aout_q;
  assign a_oe      = aoe_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Randomized bench for bus_cycle_ctrl: a transaction-level bus timeline model
// predicts pin phases, HOLD handover and responses from the request stream.
module tb_bus_cycle_ctrl;
  localparam int unsigned MAX_WAIT = 15;

  typedef struct {
    logic        write;
    logic        io;
    logic [19:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  d;
    int unsigned n;
  } txn_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_io = 1'b0;
  logic [19:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        READY = 1'b0;
  logic [7:0]  ad_in = '0;
  logic        hold_dir = 1'b0, hold_rnd = 1'b0, hold_en = 1'b0;
  logic        HOLD;
  logic        req_ready, rsp_valid, rsp_err, HLDA, ALE, IOM, RD, WR, DTR, DEN, SSO;
  logic        ad_oe, a_oe;
  logic [7:0]  rsp_rdata, ad_out;
  logic [11:0] a_out;

  assign HOLD = hold_dir | (hold_en & hold_rnd);

  bus_cycle_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_io(req_io), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .READY(READY), .HOLD(HOLD), .HLDA(HLDA), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
    .DTR(DTR), .DEN(DEN), .SSO(SSO), .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in),
    .a_out(a_out), .a_oe(a_oe)
  );

  always #5 CLK = ~CLK;

  int unsigned n_cmp = 0, n_bad = 0;
  txn_t exp_q[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Scoreboard / timeline model. Cycle k of a transaction: 1=T1, 2..3+w strobe
  // (T2, T3, w waits), 4+w = T4 with the response; w = min(n, MAX_WAIT).
  logic        inflight = 1'b0, p_inflight = 1'b0, exp_hlda = 1'b0;
  logic        p_hold = 1'b0, p_reset = 1'b1, p_accept = 1'b0, done;
  int unsigned k = 0, w = 0;
  txn_t        cur;
  logic [30:0] act_v, exp_v, msk_v;

  always @(negedge CLK) begin
    done = 1'b0;
    if (p_reset) begin
      if (inflight) void'(exp_q.pop_front());
      inflight = 1'b0;
      exp_hlda = 1'b0;
    end else begin
      exp_hlda = p_hold && !p_inflight;
      if (inflight) k++;
      else if (p_accept) begin
        inflight = 1'b1;
        k = 1;
      end
    end
    if (inflight && exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      inflight = 1'b0;
    end
    act_v = {HLDA, ALE, RD, WR, DEN, DTR, IOM, SSO, ad_oe, a_oe, rsp_valid, ad_out, a_out};
    exp_v = {exp_hlda, 10'b0_1111_000_00, 8'h00, 12'h000};
    msk_v = '1;
    if (inflight) begin
      cur = exp_q[0];
      w = (cur.n > MAX_WAIT) ? MAX_WAIT : cur.n;
      if (k == 1)
        exp_v = {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, cur.write, cur.io, cur.write, 1'b1, 1'b1,
                 1'b0, cur.addr[7:0], cur.addr[19:8]};
      else if (k <= 3 + w) begin
        exp_v = {1'b0, 1'b0, cur.write, !cur.write, 1'b0, cur.write, cur.io, cur.write,
                 cur.write, 1'b1, 1'b0, cur.wdata, cur.addr[19:8]};
        if (!cur.write) msk_v[19:12] = '0;
      end else begin
        exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 20'h0};
        msk_v[25:23] = '0;
        msk_v[19:0]  = '0;
        done = 1'b1;
      end
    end
    chk("pins", {1'b0, act_v & msk_v}, {1'b0, exp_v & msk_v});
    chk("req_ready", {31'b0, req_ready}, {31'b0, !inflight && !exp_hlda && !HOLD && !RESET});
    if (done) begin
      if (rsp_valid) begin
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, cur.n > MAX_WAIT});
        chk("rsp_rdata", {24'b0, rsp_rdata},
            {24'b0, (!cur.write && cur.n <= MAX_WAIT) ? cur.d : 8'h00});
      end
      void'(exp_q.pop_front());
    end
    // Bus responder: READY only means something from T3 on; read data is
    // presented only on the cycle READY is given.
    READY = 1'($urandom);
    ad_in = 8'($urandom);
    if (inflight && !done && k >= 3) begin
      READY = (k >= 3 + cur.n);
      if (k == 3 + cur.n) ad_in = cur.d;
    end
    p_inflight = inflight;
    if (done) inflight = 1'b0;
    p_hold   = HOLD;
    p_reset  = RESET;
    p_accept = req_valid && req_ready;
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if ($urandom_range(0, 11) == 0) begin
        hold_rnd = 1'b1;
        repeat ($urandom_range(1, 6)) @(posedge CLK);
        #1 hold_rnd = 1'b0;
      end
    end
  end

  task automatic do_req(input txn_t t);
    int unsigned guard = 0;
    req_write = t.write;
    req_io    = t.io;
    req_addr  = t.addr;
    req_wdata = t.wdata;
    req_valid = 1'b1;
    forever begin
      @(negedge CLK);
      if (req_ready) begin
        exp_q.push_back(t);
        break;
      end
      guard++;
      if (guard > 300) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_io    = 1'($urandom);
    req_addr  = 20'($urandom);
    req_wdata = 8'($urandom);
  endtask

  function automatic txn_t mk(logic wr, logic io, logic [19:0] a, logic [7:0] wd,
                              logic [7:0] d, int unsigned n);
    txn_t t;
    t.write = wr; t.io = io; t.addr = a; t.wdata = wd; t.d = d; t.n = n;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    int unsigned r = $urandom_range(0, 9);
    int unsigned n;
    if (r < 6)       n = $urandom_range(0, 3);
    else if (r < 8)  n = $urandom_range(4, 14);
    else if (r == 8) n = 15;
    else             n = $urandom_range(16, 18);
    return mk(1'($urandom), 1'($urandom), 20'($urandom), 8'($urandom), 8'($urandom), n);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    do_req(mk(1'b0, 1'b0, 20'hA5C33, 8'h00, 8'h7E, 0));
    do_req(mk(1'b1, 1'b1, 20'h00060, 8'h5A, 8'h00, 2));
    do_req(mk(1'b0, 1'b0, 20'h12345, 8'h00, 8'hC3, 16));
    do_req(mk(1'b0, 1'b1, 20'hFFFFF, 8'h00, 8'h81, 15));
    repeat (3) @(posedge CLK);
    #1;
    // HOLD raised in T2 of a read while the next request is already waiting.
    do_req(mk(1'b0, 1'b0, 20'h0BEEF, 8'h00, 8'h44, 1));
    @(posedge CLK);
    #1 hold_dir = 1'b1;
    fork
      do_req(mk(1'b1, 1'b0, 20'h54321, 8'hE7, 8'h00, 0));
      begin
        repeat (10) @(posedge CLK);
        #1 hold_dir = 1'b0;
      end
    join
    // Reset while waiting in TW: the read must vanish without a response.
    do_req(mk(1'b0, 1'b0, 20'h33333, 8'h00, 8'h99, 20));
    repeat (6) @(posedge CLK);
    #1 RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    do_req(mk(1'b0, 1'b0, 20'h01010, 8'h00, 8'h11, 0));
    do_req(mk(1'b0, 1'b1, 20'h02020, 8'h00, 8'h22, 0));
    hold_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge CLK);
      #1;
      do_req(rnd_txn());
    end
    hold_en = 1'b0;
    repeat (40) @(posedge CLK);
    #1;
    chk("drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_cycle_ctrl.md
Name: bus_cycle_ctrl

Overview:
Minimum-mode 8088 bus cycle sequencer. Accepts single-byte memory/IO read/write requests from an internal requester over a valid/ready handshake. Drives the main bus control strobes and the multiplexed AD/A address/data phases through T1-T2-T3-(TW)-T4, honouring READY wait states. Arbitrates bus ownership with an external master via HOLD/HLDA. Pin tristating is done outside the block from the output-enable ports.

Parameters:
MAX_WAIT, 15, maximum TW cycles before forced completion with error.
WAIT_W, 4, width of the wait counter; must satisfy 2**WAIT_W > MAX_WAIT.

Ports:
CLK  input  1  single clock.
RESET  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  request accepted on the CLK edge where req_valid && req_ready.
req_write  input  1  1 = write, 0 = read.
req_io  input  1  1 = IO space, 0 = memory.
req_addr  input  20  byte address.
req_wdata  input  8  write data.
rsp_valid  output  1  one-cycle completion pulse.
rsp_rdata  output  8  read data, valid with rsp_valid; 0 for writes.
rsp_err  output  1  wait timeout, valid with rsp_valid.
READY  input  1  peripheral ready; sampled in T3/TW.
HOLD  input  1  external bus request.
HLDA  output  1  hold acknowledge.
ALE  output  1  address latch enable, active high.
IOM  output  1  1 = IO cycle.
RD  output  1  read strobe, active low.
WR  output  1  write strobe, active low.
DTR  output  1  1 = transmit (write), 0 = receive.
DEN  output  1  data enable, active low.
SSO  output  1  status; equals the latched req_write during a cycle, 0 otherwise.
ad_out  output  8  value driven onto AD[7:0].
ad_oe  output  1  AD[7:0] drive enable.
ad_in  input  8  AD[7:0] as seen on the bus.
a_out  output  12  value driven onto A[19:8].
a_oe  output  1  A[19:8] drive enable.

Behaviour:
- Reset values, and values held in IDLE: state=IDLE; ALE=0, RD=1, WR=1, DEN=1, DTR=1, IOM=0, SSO=0, HLDA=0, ad_oe=0, a_oe=0, ad_out=0, a_out=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset asserted mid-cycle: reset values on the next cycle; the in-flight transaction is dropped and no rsp_valid is produced.
- States: IDLE, T1, T2, T3, TW, T4, HOLDST. All outputs are registered.
- req_ready = (state==IDLE) && !HOLD && !RESET. Accepting a request latches write, io, addr and wdata, then moves to T1.
- IDLE with HOLD=1 goes to HOLDST; HOLD has priority over req_valid.
- HOLDST: HLDA=1, all oe=0, strobes inactive. Returns to IDLE on the first cycle with HOLD=0; HLDA=0 in that IDLE cycle.
- HOLD asserted during T1..T4 is ignored until the cycle completes through T4 then IDLE.
- T1: ALE=1, a_oe=1, ad_oe=1, a_out=addr[19:8], ad_out=addr[7:0], IOM=io, DTR=write, SSO=write, DEN=1.
- T2: ALE=0; a_out and IOM/DTR/SSO held; DEN=0.
  - Read: ad_oe=0, RD=0.
  - Write: ad_oe=1, ad_out=wdata, WR=0.
- T3 and TW: strobes, DEN and drives are held as in T2.
  - READY=1 goes to T4; for a read, rsp_rdata captures ad_in on that edge.
  - READY=0 goes to TW and increments the wait counter (cleared in T1).
  - In TW with wait count == MAX_WAIT and READY=0: go to T4 with rsp_err=1; rsp_rdata=0 for a read.
- T4: RD=1, WR=1, DEN=1, ad_oe=0, a_oe=0, ALE=0; rsp_valid=1 for exactly this cycle. Next state is IDLE unconditionally.
- Back-to-back requests therefore have at least one IDLE cycle between T4 and the next T1.
- Latency: with zero waits, rsp_valid is high 4 cycles after the accept cycle (T1, T2, T3, T4); each TW adds 1 cycle.
- rsp_rdata and rsp_err hold their values until the next T1.

Test Plan:
- Memory read, addr=0x A5C3 3 (0xA5C33), ad_in=0x7E, READY=1 -> T1: ALE=1, a_out=0xA5C, ad_out=0x33, IOM=0. T2: RD=0, DEN=0, ad_oe=0. rsp_valid in the 4th cycle after accept, rsp_rdata=0x7E, rsp_err=0.
- IO write, addr=0x00060, wdata=0x5A, READY low for 2 cycles -> IOM=1, DTR=1, WR=0 for T2+T3+2TW (4 cycles), ad_out=0x5A. rsp_valid 6 cycles after accept.
- READY held 0, MAX_WAIT=15 -> exactly 15 TW cycles, then T4 with rsp_valid=1, rsp_err=1, rsp_rdata=0.
- HOLD raised during T2 with req_valid also high -> cycle completes; HLDA=1 in the cycle after IDLE; req_ready=0 while HOLD=1. HOLD drops -> IDLE, then the pending request is accepted.
- RESET pulsed during TW -> next cycle RD=1, DEN=1, ad_oe=0, a_oe=0, state IDLE; no rsp_valid ever for the dropped request.
- Two consecutive reads with req_valid held high -> second T1 starts 2 cycles after the first T4 (T4, IDLE/accept, T1); both responses carry the correct data.
